// File: rtl/sccb_pkg.sv
// sccb_pkg: shared table geometry, entry encodings and sequencer state codes
package sccb_pkg;
    localparam int TBL_W = 16;
    localparam int TBL_D = 256;
    localparam int TBL_AW = $clog2(TBL_D);
    localparam logic [TBL_W-1:0] END_ENTRY = 16'hFFFF;
    localparam logic [7:0] DELAY_REG = 8'hF0;
    typedef logic [3:0] state_t;
    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_FETCH     = 4'd1;
    localparam state_t S_DECODE    = 4'd2;
    localparam state_t S_ISSUE     = 4'd3;
    localparam state_t S_WAIT_BUSY = 4'd4;
    localparam state_t S_WAIT_DONE = 4'd5;
    localparam state_t S_WAIT_IDLE = 4'd6;
    localparam state_t S_GAP       = 4'd7;
    localparam state_t S_DELAY     = 4'd8;
    localparam state_t S_DONE      = 4'd9;
    localparam state_t S_ERROR     = 4'd10;
endpackage

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: register-init table with registered read; C_TABLE 1/2 select short and full-length alternates
module ov7670_reg_rom
    import sccb_pkg::*;
#(
    parameter int C_TABLE = 0
) (
    input  logic              clk,
    input  logic [TBL_AW-1:0] addr,
    output logic [TBL_W-1:0]  data
);
    function automatic logic [TBL_W-1:0] rom_word(input logic [TBL_AW-1:0] a);
        if (C_TABLE == 2) return {8'h01, a};
        if (C_TABLE == 1) return a == 8'd0 ? 16'h1280 : a == 8'd1 ? {DELAY_REG, 8'h02} : END_ENTRY;
        case (a)
            8'd0:    return 16'h1280;
            8'd1:    return {DELAY_REG, 8'd10};
            8'd2:    return 16'h1101;
            8'd3:    return 16'h1204;
            8'd4:    return 16'h0C00;
            8'd5:    return 16'h3E00;
            8'd6:    return 16'h40D0;
            8'd7:    return 16'h3A04;
            8'd8:    return 16'h8C00;
            8'd9:    return 16'h1713;
            8'd10:   return 16'h1801;
            8'd11:   return 16'h32B6;
            8'd12:   return 16'h1902;
            8'd13:   return 16'h1A7A;
            8'd14:   return 16'h030A;
            default: return END_ENTRY;
        endcase
    endfunction

    always_ff @(posedge clk) data <= rom_word(addr);
endmodule

// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks the register table, issuing SCCB writes, ms delays and inter-write gaps
module sccb_init_sequencer
    import sccb_pkg::*;
#(
    parameter int          C_CLK_FREQ_MHZ = 100,
    parameter logic [7:0]  C_SLAVE_ADDR   = 8'h21,
    parameter int          C_GAP_CYCLES   = 1000,
    parameter int          C_ACK_TIMEOUT  = 1024,
    parameter int          C_TABLE        = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sccb_busy,
    input  logic        sccb_done,
    output logic        wr_pulse,
    output logic [7:0]  slave_addr,
    output logic [7:0]  reg_addr,
    output logic [31:0] tx_data,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_err,
    output logic [7:0]  entry_idx
);
    localparam int TICK = C_CLK_FREQ_MHZ * 1000;
    state_t state;
    logic [TBL_W-1:0] rom_data;
    logic [15:0] gap_cnt, to_cnt;
    logic [19:0] pre_cnt;
    logic [7:0] ms_cnt;
    logic gap_last, to_last, tick_last;

    ov7670_reg_rom #(.C_TABLE(C_TABLE)) u_rom (.clk(clk), .addr(entry_idx), .data(rom_data));

    assign slave_addr = {1'b0, C_SLAVE_ADDR[6:0]};
    assign init_done  = state == S_DONE;
    assign init_err   = state == S_ERROR;
    assign init_busy  = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign gap_last   = int'(gap_cnt) + 1 >= C_GAP_CYCLES;
    assign to_last    = int'(to_cnt) + 1 >= C_ACK_TIMEOUT;
    assign tick_last  = int'(pre_cnt) + 1 >= TICK;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_pulse  <= 1'b0;
            reg_addr  <= '0;
            tx_data   <= '0;
            entry_idx <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            pre_cnt   <= '0;
            ms_cnt    <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: if (start) begin
                    entry_idx <= '0;
                    state     <= S_FETCH;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: if (rom_data == END_ENTRY) state <= S_DONE;
                else if (rom_data[15:8] == DELAY_REG) begin
                    ms_cnt  <= rom_data[7:0];
                    pre_cnt <= '0;
                    gap_cnt <= '0;
                    state   <= rom_data[7:0] == 8'd0 ? S_GAP : S_DELAY;
                end else begin
                    reg_addr <= rom_data[15:8];
                    tx_data  <= {24'd0, rom_data[7:0]};
                    state    <= S_ISSUE;
                end
                S_ISSUE: if (!sccb_busy) begin
                    wr_pulse <= 1'b1;
                    to_cnt   <= '0;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: if (sccb_busy) state <= S_WAIT_DONE;
                else if (to_last) state <= S_ERROR;
                else to_cnt <= to_cnt + 16'd1;
                S_WAIT_DONE: if (sccb_done) state <= S_WAIT_IDLE;
                S_WAIT_IDLE: if (!sccb_done) begin
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: if (gap_last) begin
                    gap_cnt <= '0;
                    if (entry_idx == 8'hFF) state <= S_DONE;
                    else begin
                        entry_idx <= entry_idx + 8'd1;
                        state     <= S_FETCH;
                    end
                end else gap_cnt <= gap_cnt + 16'd1;
                S_DELAY: if (tick_last) begin
                    pre_cnt <= '0;
                    ms_cnt  <= ms_cnt - 8'd1;
                    if (ms_cnt == 8'd1) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end else pre_cnt <= pre_cnt + 20'd1;
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer: three sequencers (real, 3-entry, 256-write tables) against a simple controller model
module tb_sccb_init_sequencer;
    localparam int TO = 32;
    localparam int LAT = 50;

    typedef struct {
        int         inst;
        bit         nobusy;
        int         budget;
        bit         done;
        bit         err;
        logic [7:0] idx;
        int         pulses;
        logic [7:0] reg_a;
        logic [7:0] dat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n = '0, start = '0, force_busy = '0, nobusy = '0;
    logic [2:0] sccb_busy, sccb_done, wr_pulse, init_busy, init_done, init_err;
    logic [2:0][7:0] slave_addr, reg_addr, entry_idx;
    logic [2:0][31:0] tx_data;
    logic [2:0] mb = '0, md = '0, width_err = '0, prev_wp = '0;
    int ph [3], cnt [3], pcnt [3], last_cyc [3];
    logic [7:0] last_reg [3], last_dat [3];
    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    vec_t vecs [4];
    int p0, g, lat_i, diff;
    bit ok;

    assign sccb_busy = mb | force_busy;
    assign sccb_done = md;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        sccb_init_sequencer #(
            .C_CLK_FREQ_MHZ(1), .C_SLAVE_ADDR(8'h21), .C_GAP_CYCLES(4),
            .C_ACK_TIMEOUT(TO), .C_TABLE(i)
        ) dut (
            .clk(clk), .rst_n(rst_n[i]), .start(start[i]),
            .sccb_busy(sccb_busy[i]), .sccb_done(sccb_done[i]),
            .wr_pulse(wr_pulse[i]), .slave_addr(slave_addr[i]), .reg_addr(reg_addr[i]),
            .tx_data(tx_data[i]), .init_busy(init_busy[i]), .init_done(init_done[i]),
            .init_err(init_err[i]), .entry_idx(entry_idx[i])
        );
    end

    // controller model: busy LAT clocks after a pulse, then done for two clocks; plus pulse tracking
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (wr_pulse[k]) begin
                pcnt[k]     <= pcnt[k] + 1;
                last_cyc[k] <= cyc;
                last_reg[k] <= reg_addr[k];
                last_dat[k] <= tx_data[k][7:0];
            end
            if (wr_pulse[k] && prev_wp[k]) width_err[k] <= 1'b1;
            prev_wp[k] <= wr_pulse[k];
            if (!rst_n[k]) begin
                ph[k] <= 0;
                mb[k] <= 1'b0;
                md[k] <= 1'b0;
            end else if (ph[k] == 0) begin
                if (wr_pulse[k] && !nobusy[k]) begin
                    ph[k]  <= 1;
                    mb[k]  <= 1'b1;
                    cnt[k] <= LAT;
                end
            end else if (ph[k] == 1) begin
                cnt[k] <= cnt[k] - 1;
                if (cnt[k] == 1) begin
                    mb[k]  <= 1'b0;
                    md[k]  <= 1'b1;
                    ph[k]  <= 2;
                    cnt[k] <= 2;
                end
            end else begin
                cnt[k] <= cnt[k] - 1;
                if (cnt[k] == 1) begin
                    md[k] <= 1'b0;
                    ph[k] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_end(input int k, input int budget, output bit res);
        res = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done[k] || init_err[k]) begin
                res = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pcnt(input int k, input int target, input int budget, output bit res);
        res = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pcnt[k] >= target) begin
                res = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 1'b0, 4000, 1'b1, 1'b0, 8'd2, 1, 8'h12, 8'h80};
        vecs[1] = '{1, 1'b1, 4000, 1'b0, 1'b1, 8'd0, 1, 8'h12, 8'h80};
        vecs[2] = '{2, 1'b0, 20000, 1'b1, 1'b0, 8'd255, 256, 8'h01, 8'hFF};
        vecs[3] = '{0, 1'b0, 15000, 1'b1, 1'b0, 8'd15, 14, 8'h03, 8'h0A};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_wr_pulse", k), 32'(wr_pulse[k]), 0);
            chk($sformatf("rst%0d_reg_addr", k), 32'(reg_addr[k]), 0);
            chk($sformatf("rst%0d_tx_data", k), tx_data[k], 0);
            chk($sformatf("rst%0d_entry_idx", k), 32'(entry_idx[k]), 0);
            chk($sformatf("rst%0d_flags", k), {29'd0, init_busy[k], init_done[k], init_err[k]}, 0);
            chk($sformatf("rst%0d_slave_addr", k), 32'(slave_addr[k]), 32'h21);
        end
        rst_n = '1;
        @(negedge clk);

        foreach (vecs[i]) begin
            g = vecs[i].inst;
            nobusy[g] = vecs[i].nobusy;
            p0 = pcnt[g];
            pulse_start(g);
            wait_end(g, vecs[i].budget, ok);
            chk($sformatf("v%0d_terminated", i), 32'(ok), 1);
            diff = cyc - last_cyc[g];
            if (vecs[i].nobusy) chk($sformatf("v%0d_timeout_clocks", i), diff, TO);
            if (g == 1 && !vecs[i].nobusy)
                chk($sformatf("v%0d_delay_window", i), 32'(diff >= 2000 && diff <= 2150), 1);
            chk($sformatf("v%0d_init_done", i), 32'(init_done[g]), 32'(vecs[i].done));
            chk($sformatf("v%0d_init_err", i), 32'(init_err[g]), 32'(vecs[i].err));
            chk($sformatf("v%0d_init_busy", i), 32'(init_busy[g]), 0);
            chk($sformatf("v%0d_entry_idx", i), 32'(entry_idx[g]), 32'(vecs[i].idx));
            chk($sformatf("v%0d_reg_addr", i), 32'(reg_addr[g]), 32'(vecs[i].reg_a));
            chk($sformatf("v%0d_tx_data", i), tx_data[g], {24'd0, vecs[i].dat});
            repeat (50) @(negedge clk);
            chk($sformatf("v%0d_pulses", i), pcnt[g] - p0, vecs[i].pulses);
            chk($sformatf("v%0d_held", i), {30'd0, init_done[g], init_err[g]}, {30'd0, vecs[i].done, vecs[i].err});
            chk($sformatf("v%0d_pulse_width", i), 32'(width_err[g]), 0);
            nobusy[g] = 1'b0;
        end

        // controller busy while ISSUE is pending: pulse must wait, then last one clock
        force_busy[1] = 1'b1;
        p0 = pcnt[1];
        pulse_start(1);
        repeat (20) @(negedge clk);
        chk("busyhold_no_pulse", pcnt[1] - p0, 0);
        chk("busyhold_init_busy", 32'(init_busy[1]), 1);
        force_busy[1] = 1'b0;
        lat_i = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (wr_pulse[1]) begin
                lat_i = i;
                break;
            end
        end
        chk("busyhold_release_latency", lat_i, 1);
        @(negedge clk);
        chk("busyhold_pulse_width", 32'(wr_pulse[1]), 0);
        wait_end(1, 4000, ok);
        chk("busyhold_done", 32'(ok && init_done[1]), 1);
        chk("busyhold_width_flag", 32'(width_err[1]), 0);

        // start mid-transfer is ignored; start in DONE reruns the table
        p0 = pcnt[1];
        pulse_start(1);
        for (int i = 0; i < 20 && !sccb_busy[1]; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        pulse_start(1);
        wait_end(1, 4000, ok);
        repeat (10) @(negedge clk);
        chk("midstart_done", 32'(ok && init_done[1]), 1);
        chk("midstart_pulses", pcnt[1] - p0, 1);
        chk("midstart_entry_idx", 32'(entry_idx[1]), 2);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("rerun_done_cleared", 32'(init_done[1]), 0);
        chk("rerun_busy", 32'(init_busy[1]), 1);
        chk("rerun_entry_idx", 32'(entry_idx[1]), 0);
        wait_end(1, 4000, ok);
        chk("rerun_done", 32'(ok && init_done[1]), 1);
        chk("rerun_pulses", pcnt[1] - p0, 2);

        // reset asserted while entry 3 is in flight on the real table
        p0 = pcnt[0];
        pulse_start(0);
        wait_pcnt(0, p0 + 3, 15000, ok);
        chk("midrst_reached_entry3", 32'(ok), 1);
        repeat (10) @(negedge clk);
        chk("midrst_entry_idx", 32'(entry_idx[0]), 3);
        chk("midrst_reg_addr", 32'(reg_addr[0]), 32'h12);
        chk("midrst_tx_data", tx_data[0], 32'h04);
        chk("midrst_busy", 32'(init_busy[0]), 1);
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_async_idx_reg", {16'd0, entry_idx[0], reg_addr[0]}, 0);
        chk("midrst_async_tx_data", tx_data[0], 0);
        chk("midrst_async_flags", {28'd0, wr_pulse[0], init_busy[0], init_done[0], init_err[0]}, 0);
        repeat (100) @(negedge clk);
        chk("midrst_no_more_pulses", pcnt[0] - p0, 3);
        rst_n[0] = 1'b1;
        @(negedge clk);
        pulse_start(0);
        wait_pcnt(0, p0 + 4, 20, ok);
        chk("midrst_restart_pulse", 32'(ok), 1);
        chk("midrst_restart_reg", 32'(last_reg[0]), 32'h12);
        chk("midrst_restart_data", 32'(last_dat[0]), 32'h80);
        chk("midrst_restart_idx", 32'(entry_idx[0]), 0);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sccb_init_sequencer.md
SCCB_INIT_SEQUENCER -- requirements
Module: sccb_init_sequencer

Interface
REQ-001 SHALL have parameter C_CLK_FREQ_MHZ, default 100, system clock frequency used to derive the 1 ms tick.
REQ-002 SHALL have parameter C_SLAVE_ADDR, default 8'h21, 7-bit camera address placed on slave_addr[6:0] (bit 7 = 0).
REQ-003 SHALL have parameter C_GAP_CYCLES, default 1000, idle clocks inserted between consecutive writes.
REQ-004 SHALL have parameter C_ACK_TIMEOUT, default 1024, maximum clocks to wait for sccb_busy to rise after wr_pulse.
REQ-005 SHALL have ports: clk input 1, system clock; rst_n input 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start input 1: single-cycle request to run the table from entry 0.
REQ-007 SHALL have ports sccb_busy input 1 and sccb_done input 1: controller busy and transfer-done status bits.
REQ-008 SHALL have ports wr_pulse output 1, slave_addr output 8, reg_addr output 8, tx_data output 32: write request to the controller.
REQ-009 SHALL have ports init_busy output 1, init_done output 1, init_err output 1, entry_idx output 8 (current table index).

Function
REQ-010 Table is 256 x 16-bit entries {reg[15:8], data[7:0]}; 16'hFFFF = end of table; reg 8'hF0 = delay of data ms, no bus write.
REQ-011 States: IDLE, FETCH, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, WAIT_IDLE, GAP, DELAY, DONE, ERROR.
REQ-012 IDLE: on start=1, entry_idx<=0, clear init_done/init_err, go to FETCH; start is ignored in every other state except DONE and ERROR, where it behaves as in IDLE.
REQ-013 FETCH: present entry_idx to the table (1-cycle synchronous read), go to DECODE.
REQ-014 DECODE: FFFF -> DONE; reg==F0 -> DELAY with the ms counter loaded from data (0 = no delay, go straight to GAP); otherwise latch reg_addr/tx_data[7:0] (tx_data[31:8]=0) and go to ISSUE.
REQ-015 ISSUE: assert wr_pulse for exactly one clock, only if sccb_busy==0, else hold in ISSUE; next state WAIT_BUSY.
REQ-016 WAIT_BUSY: sccb_busy==1 -> WAIT_DONE; C_ACK_TIMEOUT clocks elapsed without it -> ERROR.
REQ-017 WAIT_DONE: sccb_done==1 -> WAIT_IDLE; WAIT_IDLE: sccb_done==0 -> GAP (transfer fully returned to idle).
REQ-018 GAP: count C_GAP_CYCLES clocks, then entry_idx<=entry_idx+1 and FETCH; if entry_idx==255, go to DONE instead (no wrap).
REQ-019 DELAY: 1 ms tick = C_CLK_FREQ_MHZ*1000 clocks; decrement per tick, at 0 go to GAP.
REQ-020 DONE: init_done=1, init_busy=0, hold until start. ERROR: init_err=1, init_busy=0, entry_idx frozen at failing entry, hold until start.
REQ-021 init_busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-022 slave_addr SHALL be constant {1'b0, C_SLAVE_ADDR[6:0]}; reg_addr/tx_data SHALL remain stable from ISSUE through WAIT_IDLE.
REQ-023 Counters SHALL be sized for the parameter maxima: gap 16 bit, timeout 16 bit, ms-prescaler 20 bit, ms-count 8 bit.

Reset
REQ-024 On rst_n low: state IDLE, wr_pulse 0, reg_addr 0, tx_data 0, entry_idx 0, init_busy/init_done/init_err 0, all counters 0.
REQ-025 Reset asserted mid-sequence SHALL abort immediately, and no further wr_pulse SHALL be issued until a new start.

Structure
REQ-026 Entry encodings (END 16'hFFFF, DELAY reg 8'hF0), the state encoding and the table width/depth SHALL be in a shared package, sccb_pkg.
REQ-027 The table SHALL be a sub-module ov7670_reg_rom (clk, addr[7:0] -> data[15:0], registered output); the first entry SHALL be {8'h12, 8'h80} (soft reset), followed by {8'hF0, 8'd10}.

Verification
REQ-028 3-entry table {12/80, F0/02, FFFF}, controller model done 50 clk after busy -> one wr_pulse (reg 12, data 80), ~2 ms gap, init_done=1 with entry_idx=2.
REQ-029 Model never raises sccb_busy -> init_err=1 exactly C_ACK_TIMEOUT clocks after wr_pulse, entry_idx=0, no second wr_pulse.
REQ-030 sccb_busy held high at ISSUE for 20 clocks -> wr_pulse is delayed until busy=0, pulse width 1.
REQ-031 rst_n pulled low during WAIT_DONE of entry 3 -> all outputs return to reset values in the same clock; a subsequent start restarts at entry 0.
REQ-032 start pulsed during WAIT_DONE -> ignored; start pulsed in DONE -> full table rerun, init_done cleared at the same edge.
REQ-033 256 non-terminated write entries -> 256 wr_pulses, then DONE with entry_idx=255, with no wrap to 0.
